// File: rtl/spi_tx_queue_if.sv
//------------------------------------------------------------------------------
// spi_tx_queue_if : CPU write port and SPI shifter load port of spi_tx_queue.
// Optional overflow signals are present when SPI_TX_QUEUE_OVERFLOW_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_tx_queue_if #(
  parameter int DEPTH = 8
) ();
  logic                      wrEn;
  logic [15:0]               wrData;
  logic [15:0]               data;
  logic                      writeSPI;
  logic                      full;
  logic                      empty;
  logic [$clog2(DEPTH):0]    count;
`ifdef SPI_TX_QUEUE_OVERFLOW_EN
  logic                      overflow;
  logic                      clearOverflow;
`endif

  modport master (
    output wrEn,
    output wrData,
`ifdef SPI_TX_QUEUE_OVERFLOW_EN
    output clearOverflow,
    input  overflow,
`endif
    input  data,
    input  writeSPI,
    input  full,
    input  empty,
    input  count
  );

  modport slave (
    input  wrEn,
    input  wrData,
`ifdef SPI_TX_QUEUE_OVERFLOW_EN
    input  clearOverflow,
    output overflow,
`endif
    output data,
    output writeSPI,
    output full,
    output empty,
    output count
  );
endinterface

`default_nettype wire

// File: rtl/spi_tx_queue.sv
//------------------------------------------------------------------------------
// spi_tx_queue : FIFO feeding a 16-bit SPI shifter, strobes spaced WORD_CYCLES.
// Optional sticky overflow flag: define SPI_TX_QUEUE_OVERFLOW_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_tx_queue #(
  parameter int DEPTH       = 8,
  parameter int WORD_CYCLES = 16
) (
  input  wire logic       clock,
  input  wire logic       resetN,
  spi_tx_queue_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(WORD_CYCLES + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(WORD_CYCLES - 1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [GW-1:0] gap;
  logic [CW-1:0] countNext;
  logic          pop;
  logic          push;

  // Issue looks only at registered state, so a word written this cycle waits one more.
  assign pop  = (bus.count != '0) && (gap == '0);
  assign push = bus.wrEn && (!bus.full || pop);

  always_comb begin
    countNext = bus.count;
    if (push && !pop)
      countNext = bus.count + 1'b1;
    else if (pop && !push)
      countNext = bus.count - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push)
      mem[wrPtr] <= bus.wrData;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      gap          <= '0;
      bus.count    <= '0;
      bus.full     <= 1'b0;
      bus.empty    <= 1'b1;
      bus.writeSPI <= 1'b0;
      bus.data     <= 16'h0000;
    end else begin
      bus.count    <= countNext;
      bus.full     <= (countNext == FULL_COUNT);
      bus.empty    <= (countNext == '0);
      bus.writeSPI <= pop;
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        bus.data <= mem[rdPtr];
        rdPtr    <= rdPtr + 1'b1;
        gap      <= GAP_RELOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end

`ifdef SPI_TX_QUEUE_OVERFLOW_EN
  // Set has priority over clear so a drop is never masked.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      bus.overflow <= 1'b0;
    else if (bus.wrEn && bus.full && !pop)
      bus.overflow <= 1'b1;
    else if (bus.clearOverflow)
      bus.overflow <= 1'b0;
  end
`endif

endmodule

`default_nettype wire
